// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller over a dual-port RAM with a 2-entry read skid buffer
module ram_fifo_ctrl #(
   parameter int DEPTH  = 16,
   parameter int DWIDTH = 8,
   parameter int AWIDTH = $clog2(DEPTH),
   parameter int CWIDTH = $clog2(DEPTH + 3)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_valid,
   output logic              push_ready,
   input  logic [DWIDTH-1:0] push_data,
   output logic              pop_valid,
   input  logic              pop_ready,
   output logic [DWIDTH-1:0] pop_data,
   output logic              wr_enbl,
   output logic [AWIDTH-1:0] wr_addr,
   output logic [DWIDTH-1:0] wr_data,
   output logic              rd_enbl,
   output logic [AWIDTH-1:0] rd_addr,
   input  logic [DWIDTH-1:0] rd_data,
   output logic [CWIDTH-1:0] count,
   output logic              full,
   output logic              empty
);

   logic [AWIDTH-1:0] wr_ptr, rd_ptr;
   logic [CWIDTH-1:0] ram_cnt;
   logic              rd_pend;
   logic [1:0]        buf_cnt, buf_cnt_n;
   logic [DWIDTH-1:0] slot0, slot1, slot0_n, slot1_n;
   logic              push_fire, pop_fire;
   logic [2:0]        occ_after_pop;

   function automatic logic [AWIDTH-1:0] ptr_inc(input logic [AWIDTH-1:0] p);
      return (p == AWIDTH'(DEPTH - 1)) ? '0 : p + AWIDTH'(1);
   endfunction

   assign full       = (ram_cnt == CWIDTH'(DEPTH));
   assign push_ready = rst & ~full;
   assign push_fire  = push_valid & push_ready;
   assign pop_valid  = (buf_cnt != 2'd0);
   assign pop_fire   = pop_valid & pop_ready;
   assign pop_data   = slot0;

   // Buffered plus in-flight words must stay within the two skid slots.
   assign occ_after_pop = {1'b0, buf_cnt} + {2'b00, rd_pend} - {2'b00, pop_fire};
   assign rd_enbl       = (ram_cnt != '0) & (occ_after_pop < 3'd2);

   assign wr_enbl = push_fire;
   assign wr_addr = wr_ptr;
   assign wr_data = push_data;
   assign rd_addr = rd_ptr;

   assign count = ram_cnt + CWIDTH'(rd_pend) + CWIDTH'(buf_cnt);
   assign empty = (count == '0);

   // Pop shifts first, then the returning read lands in the first free slot.
   always_comb begin
      buf_cnt_n = buf_cnt;
      slot0_n   = slot0;
      slot1_n   = slot1;
      if (pop_fire) begin
         slot0_n   = slot1;
         buf_cnt_n = buf_cnt - 2'd1;
      end
      if (rd_pend) begin
         if (buf_cnt_n == 2'd0) slot0_n = rd_data;
         else                   slot1_n = rd_data;
         buf_cnt_n = buf_cnt_n + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ram_cnt <= '0;
         rd_pend <= 1'b0;
         buf_cnt <= 2'd0;
         slot0   <= '0;
         slot1   <= '0;
      end else begin
         if (push_fire) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_enbl)   rd_ptr <= ptr_inc(rd_ptr);
         ram_cnt <= ram_cnt + CWIDTH'(push_fire) - CWIDTH'(rd_enbl);
         rd_pend <= rd_enbl;
         buf_cnt <= buf_cnt_n;
         slot0   <= slot0_n;
         slot1   <= slot1_n;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - self-checking bench for ram_fifo_ctrl with a RAM model and queue scoreboard
module tb_ram_fifo_ctrl;
   localparam int DEPTH  = 16;
   localparam int DWIDTH = 8;
   localparam int AWIDTH = $clog2(DEPTH);
   localparam int CWIDTH = $clog2(DEPTH + 3);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              push_valid = 1'b0;
   logic              pop_ready = 1'b0;
   logic [DWIDTH-1:0] push_data = '0;
   logic              push_ready, pop_valid, wr_enbl, rd_enbl, full, empty;
   logic [DWIDTH-1:0] pop_data, wr_data;
   logic [DWIDTH-1:0] rd_data = '0;
   logic [AWIDTH-1:0] wr_addr, rd_addr;
   logic [CWIDTH-1:0] count;

   int checks = 0;
   int failures = 0;
   logic [DWIDTH-1:0] q[$];
   int inflight = 0;
   logic [DWIDTH-1:0] mem [DEPTH];

   ram_fifo_ctrl #(.DEPTH(DEPTH), .DWIDTH(DWIDTH)) dut (
      .clk(clk), .rst(rst_n),
      .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
      .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
      .wr_enbl(wr_enbl), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_enbl(rd_enbl), .rd_addr(rd_addr), .rd_data(rd_data),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // Dual-port RAM with one-cycle registered read; unaffected by controller reset.
   always @(posedge clk) begin
      if (wr_enbl) mem[wr_addr] <= wr_data;
      if (rd_enbl) rd_data <= mem[rd_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exhausted");
      $fatal(1);
   end

   task automatic drive(input logic pv, input logic [DWIDTH-1:0] pd, input logic pr);
      push_valid = pv;
      push_data  = pd;
      pop_ready  = pr;
      #1;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard bookkeeping for the coming edge (pushes enqueue; reads/pops tracked as a tally).
   task automatic model_edge();
      if (push_valid && push_ready) q.push_back(push_data);
      inflight = inflight + int'(rd_enbl) - int'(pop_valid && pop_ready);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 8'h11, 1'b1);
      advance();
      checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL rst_push_ready: got %b want 0", push_ready); end
      checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL rst_pop_valid: got %b want 0", pop_valid); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full: got %b want 0", full); end
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty: got %b want 1", empty); end
      checks++; if (count !== 0) begin failures++; $display("FAIL rst_count: got %0d want 0", count); end
      checks++; if ({wr_enbl, rd_enbl} !== 2'b00) begin failures++; $display("FAIL rst_strobes: got %b want 00", {wr_enbl, rd_enbl}); end
      checks++; if ({wr_addr, rd_addr} !== '0) begin failures++; $display("FAIL rst_addrs: got %h want 0", {wr_addr, rd_addr}); end
      drive(1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      #1;
      checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b want 1", push_ready); end
      advance();
   endtask

   task automatic test_single();
      drive(1'b1, 8'hA5, 1'b1);
      advance();
      drive(1'b0, 8'h00, 1'b1);
      checks++; if (rd_enbl !== 1'b1) begin failures++; $display("FAIL single_rd_enbl: got %b want 1", rd_enbl); end
      checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL single_early1: got %b want 0", pop_valid); end
      advance();
      checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL single_early2: got %b want 0", pop_valid); end
      advance();
      checks++; if (pop_valid !== 1'b1) begin failures++; $display("FAIL single_pop_valid: got %b want 1", pop_valid); end
      checks++; if (pop_data !== 8'hA5) begin failures++; $display("FAIL single_pop_data: got %h want a5", pop_data); end
      advance();
      checks++; if (empty !== 1'b1 || count !== 0) begin failures++; $display("FAIL single_empty_after: got empty=%b count=%0d want 1/0", empty, count); end
      drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_%0d: got %b want 1", i, push_ready); end
         advance();
      end
      drive(1'b0, 8'h00, 1'b0);
      repeat (3) advance();
      checks++; if (count !== 16) begin failures++; $display("FAIL fill_count16: got %0d want 16", count); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL fill_not_full: got %b want 0", full); end
      checks++; if (pop_valid !== 1'b1 || pop_data !== 8'h00) begin failures++; $display("FAIL fill_head: got v=%b d=%h want 1/00", pop_valid, pop_data); end
      for (int i = 16; i < 18; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         advance();
      end
      drive(1'b1, 8'h99, 1'b0);
      checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full: got %b want 1", full); end
      checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL fill_push_ready: got %b want 0", push_ready); end
      checks++; if (count !== 18) begin failures++; $display("FAIL fill_count18: got %0d want 18", count); end
      advance();
      checks++; if (count !== 18) begin failures++; $display("FAIL fill_blocked_push: got %0d want 18", count); end
      drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_drain();
      for (int i = 0; i < 18; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         checks++; if (pop_valid !== 1'b1 || pop_data !== 8'(i)) begin failures++; $display("FAIL drain_%0d: got v=%b d=%h want 1/%h", i, pop_valid, pop_data, 8'(i)); end
         checks++; if (count !== CWIDTH'(18 - i)) begin failures++; $display("FAIL drain_count_%0d: got %0d want %0d", i, count, 18 - i); end
         advance();
      end
      checks++; if (empty !== 1'b1 || pop_valid !== 1'b0) begin failures++; $display("FAIL drain_empty: got e=%b v=%b want 1/0", empty, pop_valid); end
      drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_back_to_back();
      int pushed = 0;
      logic [DWIDTH-1:0] exp;
      q.delete();
      inflight = 0;
      for (int cyc = 0; cyc < 110; cyc++) begin
         drive(pushed < 100, 8'($urandom), 1'b1);
         checks++; if (count !== CWIDTH'(q.size())) begin failures++; $display("FAIL b2b_count c%0d: got %0d want %0d", cyc, count, q.size()); end
         if (cyc >= 3 && pushed < 100) begin
            checks++; if (pop_valid !== 1'b1 || count !== 3) begin failures++; $display("FAIL b2b_bubble c%0d: got v=%b count=%0d want 1/3", cyc, pop_valid, count); end
         end
         if (pop_valid) begin
            exp = (q.size() > 0) ? q.pop_front() : 'x;
            checks++; if (pop_data !== exp) begin failures++; $display("FAIL b2b_data c%0d: got %h want %h", cyc, pop_data, exp); end
         end
         if (push_valid && push_ready) pushed++;
         model_edge();
         advance();
      end
      checks++; if (q.size() != 0 || empty !== 1'b1) begin failures++; $display("FAIL b2b_leftover: got q=%0d empty=%b want 0/1", q.size(), empty); end
      drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_random();
      logic [DWIDTH-1:0] exp;
      int pop_pct;
      q.delete();
      inflight = 0;
      for (int cyc = 0; cyc < 640; cyc++) begin
         pop_pct = (cyc < 300) ? 50 : (cyc < 450) ? 15 : (cyc < 600) ? 50 : 100;
         drive((cyc < 600) && ($urandom_range(0, 99) < 50), 8'($urandom), $urandom_range(0, 99) < pop_pct);
         checks++; if (count !== CWIDTH'(q.size())) begin failures++; $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, count, q.size()); end
         checks++; if (empty !== (q.size() == 0)) begin failures++; $display("FAIL rnd_empty c%0d: got %b want %b", cyc, empty, q.size() == 0); end
         checks++; if (push_ready !== !full) begin failures++; $display("FAIL rnd_ready c%0d: got ready=%b full=%b", cyc, push_ready, full); end
         if (full) begin
            checks++; if (q.size() < DEPTH) begin failures++; $display("FAIL rnd_full_early c%0d: got held=%0d want >=%0d", cyc, q.size(), DEPTH); end
         end
         if (q.size() > DEPTH + 1) begin
            checks++; if (full !== 1'b1) begin failures++; $display("FAIL rnd_full_missing c%0d: got %b want 1", cyc, full); end
         end
         if (rd_enbl) begin
            checks++; if (inflight - int'(pop_valid && pop_ready) >= 2) begin failures++; $display("FAIL rnd_rd_overissue c%0d: got outstanding=%0d want <2", cyc, inflight - int'(pop_valid && pop_ready)); end
         end
         if (pop_valid && pop_ready) begin
            exp = (q.size() > 0) ? q.pop_front() : 'x;
            checks++; if (pop_data !== exp) begin failures++; $display("FAIL rnd_data c%0d: got %h want %h", cyc, pop_data, exp); end
         end
         model_edge();
         advance();
      end
      checks++; if (q.size() != 0 || count !== 0) begin failures++; $display("FAIL rnd_drain: got q=%0d count=%0d want 0/0", q.size(), count); end
      drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_reset_midop();
      logic seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'h50 + 8'(i), 1'b0);
         advance();
      end
      drive(1'b0, 8'h00, 1'b0);
      repeat (3) advance();
      checks++; if (count !== 5) begin failures++; $display("FAIL mid_count5: got %0d want 5", count); end
      drive(1'b1, 8'h55, 1'b1);
      checks++; if (rd_enbl !== 1'b1) begin failures++; $display("FAIL mid_rd_enbl: got %b want 1", rd_enbl); end
      advance();
      checks++; if (count !== 5) begin failures++; $display("FAIL mid_count_inflight: got %0d want 5", count); end
      push_valid = 1'b0;
      pop_ready  = 1'b0;
      rst_n      = 1'b0;
      #1;
      checks++; if (count !== 0 || pop_valid !== 1'b0 || push_ready !== 1'b0) begin failures++; $display("FAIL mid_async: got count=%0d v=%b r=%b want 0/0/0", count, pop_valid, push_ready); end
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         advance();
         checks++; if (pop_valid !== 1'b0 || count !== 0) begin failures++; $display("FAIL mid_stale_%0d: got v=%b count=%0d want 0/0", i, pop_valid, count); end
      end
      checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after: got %b want 1", push_ready); end
      drive(1'b1, 8'h3C, 1'b0);
      advance();
      drive(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 6 && !seen; i++) begin
         advance();
         seen = pop_valid;
      end
      checks++; if (!seen || pop_data !== 8'h3C) begin failures++; $display("FAIL mid_post_data: got v=%b d=%h want 1/3c", seen, pop_data); end
      drive(1'b0, 8'h00, 1'b1);
      advance();
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mid_final_empty: got %b want 1", empty); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_drain();
      test_back_to_back();
      test_random();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
